// File: rtl/muldiv_controller.sv
// muldiv_controller: iterative multiply/divide sequencer that owns the HI/LO
// registers. It runs MULT/MULTU as a 32-step shift-add multiply and DIV/DIVU
// as a 32-step restoring divide, then applies the sign fix in a final FIX cycle.
// MTHI/MTLO write HI/LO directly from idle.
// Optional feature: define MULDIV_EARLY_OUT_EN so a multiply finishes as soon
// as the remaining multiplier bits are all zero.
module muldiv_controller #(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 6
) (
  input  logic                   md_i_clk,
  input  logic                   md_i_rst,
  input  logic                   md_i_start,
  input  logic [FUNCT_WIDTH-1:0] md_i_funct,
  input  logic [DWIDTH-1:0]      md_i_rs,
  input  logic [DWIDTH-1:0]      md_i_rt,
  input  logic                   md_i_mf_req,
  input  logic                   md_i_flush,
  output logic                   md_o_busy,
  output logic                   md_o_stall,
  output logic                   md_o_done,
  output logic [DWIDTH-1:0]      md_o_hi,
  output logic [DWIDTH-1:0]      md_o_lo
);

  localparam int AW = 2 * DWIDTH;
  localparam int CW = $clog2(DWIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'('h18);
  localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'('h19);
  localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'('h1A);
  localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'('h1B);
  localparam logic [FUNCT_WIDTH-1:0] F_MTHI  = FUNCT_WIDTH'('h11);
  localparam logic [FUNCT_WIDTH-1:0] F_MTLO  = FUNCT_WIDTH'('h13);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  // Two's-complement negation of a single-width word.
  function automatic logic [DWIDTH-1:0] neg_w(input logic [DWIDTH-1:0] v);
    return ~v + DWIDTH'(1);
  endfunction

  // Two's-complement negation of a double-width product.
  function automatic logic [AW-1:0] neg_d(input logic [AW-1:0] v);
    return ~v + AW'(1);
  endfunction

  // Magnitude of an operand; unsigned ops pass the raw value through.
  function automatic logic [DWIDTH-1:0] mag(input logic signed [DWIDTH-1:0] v,
                                            input logic sgn);
    return (sgn && (v < 0)) ? neg_w(v) : v;
  endfunction

  // Control state
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              done_q;
  logic              op_div;
  logic              sign_q;
  logic              sign_r;
  logic              div_zero;

  // Datapath state
  logic [AW-1:0]     acc;      // multiply: partial product; divide: {rem, quo}
  logic [DWIDTH-1:0] op_a;     // multiplicand magnitude or divisor magnitude
  logic [DWIDTH-1:0] op_b;     // remaining multiplier bits
  logic [DWIDTH-1:0] rs_raw;   // dividend as issued, returned on divide by zero
  logic [DWIDTH-1:0] hi_q;
  logic [DWIDTH-1:0] lo_q;

  // Operand views and decode
  logic signed [DWIDTH-1:0] rs_s;
  logic signed [DWIDTH-1:0] rt_s;
  logic is_mul, is_dv, is_sgn, is_mthi, is_mtlo;

  assign rs_s = md_i_rs;
  assign rt_s = md_i_rt;

  // Decode the issued funct code into operation class and signedness.
  always_comb begin
    is_mul  = (md_i_funct == F_MULT) || (md_i_funct == F_MULTU);
    is_dv   = (md_i_funct == F_DIV)  || (md_i_funct == F_DIVU);
    is_sgn  = (md_i_funct == F_MULT) || (md_i_funct == F_DIV);
    is_mthi = (md_i_funct == F_MTHI);
    is_mtlo = (md_i_funct == F_MTLO);
  end

  // Per-step arithmetic for both iterative engines
  logic [DWIDTH:0]          mul_add;
  logic [AW-1:0]            mul_step;
  logic [AW-1:0]            mul_acc_nx;
  logic                     mul_last;
  logic                     mul_early;
  logic [DWIDTH:0]          rem_sh;
  logic signed [DWIDTH+1:0] trial;
  logic                     div_ok;
  logic [AW-1:0]            div_step;

  // One shift-add multiply step and one restoring-divide step from current state.
  always_comb begin
    mul_add  = op_b[0] ? ({1'b0, acc[AW-1:DWIDTH]} + {1'b0, op_a})
                       : {1'b0, acc[AW-1:DWIDTH]};
    mul_step = {mul_add, acc[DWIDTH-1:1]};
    mul_last = (cnt == CNT_ONE);
`ifdef MULDIV_EARLY_OUT_EN
    // Once the unconsumed multiplier bits are all zero, the remaining steps
    // only shift, so collapse them into a single barrel shift.
    mul_early  = (op_b[DWIDTH-1:1] == '0) && !mul_last;
    mul_acc_nx = mul_early ? (mul_step >> (cnt - CNT_ONE)) : mul_step;
`else
    mul_early  = 1'b0;
    mul_acc_nx = mul_step;
`endif
    rem_sh   = {acc[AW-1:DWIDTH], acc[DWIDTH-1]};
    trial    = $signed({1'b0, rem_sh} - {2'b00, op_a});
    div_ok   = (trial >= 0);
    div_step = div_ok ? {trial[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b1}
                      : {rem_sh[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b0};
  end

  // Sign-corrected results presented in the FIX cycle
  logic [AW-1:0]     fix_prod;
  logic [DWIDTH-1:0] fix_quo;
  logic [DWIDTH-1:0] fix_rem;

  // Apply the latched sign flags to the unsigned engine results.
  always_comb begin
    fix_prod = sign_q ? neg_d(acc) : acc;
    fix_quo  = sign_q ? neg_w(acc[DWIDTH-1:0]) : acc[DWIDTH-1:0];
    fix_rem  = sign_r ? neg_w(acc[AW-1:DWIDTH]) : acc[AW-1:DWIDTH];
  end

  // Sequencer: issue, iterate, fix up and write HI/LO; flush and reset abort.
  always_ff @(posedge md_i_clk) begin
    if (!md_i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      done_q   <= 1'b0;
      op_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rs_raw   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md_i_start && !md_i_flush) begin
            if (is_mul) begin
              state    <= S_MUL;
              cnt      <= CNT_LOAD;
              op_div   <= 1'b0;
              acc      <= '0;
              op_a     <= mag(rs_s, is_sgn);
              op_b     <= mag(rt_s, is_sgn);
              sign_q   <= is_sgn && (md_i_rs[DWIDTH-1] ^ md_i_rt[DWIDTH-1]);
              sign_r   <= 1'b0;
              div_zero <= 1'b0;
            end else if (is_dv) begin
              state    <= S_DIV;
              cnt      <= CNT_LOAD;
              op_div   <= 1'b1;
              acc      <= {{DWIDTH{1'b0}}, mag(rs_s, is_sgn)};
              op_a     <= mag(rt_s, is_sgn);
              op_b     <= '0;
              rs_raw   <= md_i_rs;
              sign_q   <= is_sgn && (md_i_rs[DWIDTH-1] ^ md_i_rt[DWIDTH-1]);
              sign_r   <= is_sgn && md_i_rs[DWIDTH-1];
              div_zero <= (md_i_rt == '0);
            end else if (is_mthi) begin
              hi_q <= md_i_rs;
            end else if (is_mtlo) begin
              lo_q <= md_i_rs;
            end
          end
        end
        S_MUL: begin
          if (md_i_flush) begin
            state <= S_IDLE;
          end else begin
            acc  <= mul_acc_nx;
            op_b <= op_b >> 1;
            cnt  <= mul_early ? '0 : (cnt - CNT_ONE);
            if (mul_last || mul_early) state <= S_FIX;
          end
        end
        S_DIV: begin
          if (md_i_flush) begin
            state <= S_IDLE;
          end else begin
            acc <= div_step;
            cnt <= cnt - CNT_ONE;
            if (mul_last) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!md_i_flush) begin
            done_q <= 1'b1;
            if (op_div) begin
              if (div_zero) begin
                hi_q <= rs_raw;
                lo_q <= '1;
              end else begin
                hi_q <= fix_rem;
                lo_q <= fix_quo;
              end
            end else begin
              hi_q <= fix_prod[AW-1:DWIDTH];
              lo_q <= fix_prod[DWIDTH-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md_o_busy  = (state != S_IDLE);
  assign md_o_stall = md_o_busy && (md_i_start || md_i_mf_req);
  assign md_o_done  = done_q;
  assign md_o_hi    = hi_q;
  assign md_o_lo    = lo_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Testbench for muldiv_controller: directed and randomized mul/div/mt operations
// checked against an arithmetic reference model of HI/LO and operation latency.
module tb_muldiv_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        mf_req;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_controller #(.DWIDTH(32), .FUNCT_WIDTH(6)) dut (
    .md_i_clk    (clk),
    .md_i_rst    (rst_n),
    .md_i_start  (start),
    .md_i_funct  (funct),
    .md_i_rs     (rs),
    .md_i_rt     (rt),
    .md_i_mf_req (mf_req),
    .md_i_flush  (flush),
    .md_o_busy   (busy),
    .md_o_stall  (stall),
    .md_o_done   (done),
    .md_o_hi     (hi),
    .md_o_lo     (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference result {HI, LO} from plain arithmetic on the issued operands.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      6'h18: begin p = sa * sb; return p; end
      6'h19: begin p = {32'b0, a} * {32'b0, b}; return p; end
      6'h1A: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      6'h1B: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Cycle (counting the start cycle as 0) in which done pulses.
  function automatic int ref_done_cycle(input logic [5:0] f, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 32;
    m = b;
`ifdef MULDIV_EARLY_OUT_EN
    if (f == 6'h18 || f == 6'h19) begin
      m = (f == 6'h18 && b[31]) ? (~b + 32'd1) : b;
      n = 1;
      while (n < 32 && (m >> n) != 0) n++;
    end
`endif
    return n + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mul/div in cycle 0 and observe cycles 1..40.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int mf_from, input string tag);
    logic [63:0] exp;
    logic [31:0] obs_hi, obs_lo;
    int dc, seen, busy_err, stall_err, done_err, hold_err;
    exp = ref_result(f, a, b);
    dc = ref_done_cycle(f, b);
    seen = -1; busy_err = 0; stall_err = 0; done_err = 0; hold_err = 0;
    obs_hi = 'x; obs_lo = 'x;
    start = 1'b1; funct = f; rs = a; rt = b; mf_req = 1'b0;
    tick();
    start = 1'b0; funct = 6'($urandom); rs = $urandom; rt = $urandom;
    for (int c = 1; c <= 40; c++) begin
      mf_req = (mf_from > 0) ? (c >= mf_from) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy !== (c < dc)) busy_err++;
      if (stall !== ((c < dc) && mf_req)) stall_err++;
      if (done === 1'b1 && seen < 0) seen = c;
      if (done !== (c == dc)) done_err++;
      if (c < dc && (hi !== m_hi || lo !== m_lo)) hold_err++;
      if (c == dc) begin obs_hi = hi; obs_lo = lo; end
      tick();
    end
    mf_req = 1'b0;
    check({tag, " hi"}, obs_hi, exp[63:32]);
    check({tag, " lo"}, obs_lo, exp[31:0]);
    check({tag, " done cycle"}, seen, dc);
    check({tag, " done pulse errs"}, done_err, 0);
    check({tag, " busy errs"}, busy_err, 0);
    check({tag, " stall errs"}, stall_err, 0);
    check({tag, " hold errs"}, hold_err, 0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  // Issue an MTHI/MTLO (or ignored code) from idle and check the next cycle.
  task automatic mt(input logic [5:0] f, input logic [31:0] v, input string tag);
    start = 1'b1; funct = f; rs = v;
    tick();
    start = 1'b0;
    if (f == 6'h11) m_hi = v;
    if (f == 6'h13) m_lo = v;
    @(negedge clk);
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
    check({tag, " done"}, done, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    tick();
  endtask

  initial begin
    logic [63:0] exp;
    logic [5:0]  f;
    logic [31:0] a, b;
    int derr, serr;

    rst_n = 1'b0; start = 1'b0; funct = '0; rs = '0; rt = '0; mf_req = 1'b0; flush = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    mf_req = 1'b1;
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset stall", stall, 1'b0);
    check("reset done", done, 1'b0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    tick();
    mf_req = 1'b0;

    // Directed operations
    run_op(6'h18, 32'hFFFFFFFD, 32'd7, 0, "mult -3*7");
    run_op(6'h1B, 32'd100, 32'd7, 0, "divu 100/7");
    run_op(6'h1A, 32'hFFFFFFF9, 32'd2, 0, "div -7/2");
    run_op(6'h1B, 32'd5, 32'd0, 0, "divu 5/0");
    run_op(6'h1A, 32'hFFFFFFFB, 32'd0, 0, "div -5/0");
    run_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "multu max mfhi");
    run_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, 0, "div min/-1");
    run_op(6'h18, 32'h80000000, 32'h80000000, 0, "mult min*min");
    run_op(6'h18, 32'h12345678, 32'd0, 0, "mult x*0");
    run_op(6'h19, 32'hDEADBEEF, 32'd1, 0, "multu x*1");

    // MT paths, ignored code, and flush racing a start in idle
    mt(6'h13, 32'h0000ABCD, "mtlo");
    mt(6'h11, 32'h00000011, "mthi");
    mt(6'h3F, 32'h99999999, "ignored funct");
    start = 1'b1; flush = 1'b1; funct = 6'h13; rs = 32'h77777777;
    tick();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush+start lo", lo, m_lo);
    check("flush+start busy", busy, 1'b0);
    tick();

    // Flush in cycle 10 of a MULT
    start = 1'b1; funct = 6'h18; rs = 32'h00012345; rt = 32'h80000001;
    tick();
    start = 1'b0;
    derr = 0;
    for (int c = 1; c <= 40; c++) begin
      flush = (c == 10);
      @(negedge clk);
      if (c == 10) check("flush busy c10", busy, 1'b1);
      if (c == 11) check("flush busy c11", busy, 1'b0);
      if (done !== 1'b0) derr++;
      tick();
    end
    flush = 1'b0;
    check("flush hi", hi, 32'h11);
    check("flush lo", lo, m_lo);
    check("flush done errs", derr, 0);

    // Reset in cycle 20 of a DIV
    start = 1'b1; funct = 6'h1B; rs = 32'hCAFEF00D; rt = 32'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 20) rst_n = 1'b0;
      if (c == 21) rst_n = 1'b1;
      @(negedge clk);
      if (c == 21) begin
        check("rst mid busy", busy, 1'b0);
        check("rst mid done", done, 1'b0);
        check("rst mid hi", hi, 32'h0);
        check("rst mid lo", lo, 32'h0);
      end
      tick();
    end
    m_hi = '0; m_lo = '0;

    // MTHI presented while a MULTU is busy, held until accepted
    exp = ref_result(6'h19, 32'h12345678, 32'h9ABCDEF0);
    start = 1'b1; funct = 6'h19; rs = 32'h12345678; rt = 32'h9ABCDEF0;
    tick();
    start = 1'b0;
    serr = 0;
    for (int c = 1; c <= 36; c++) begin
      start = (c >= 3 && c <= 34);
      funct = 6'h11; rs = 32'h00005555;
      @(negedge clk);
      if (start && stall !== (c <= 33)) serr++;
      if (c == 33) check("mthi busy hi held", hi, m_hi);
      if (c == 34) begin
        check("mthi busy mul hi", hi, exp[63:32]);
        check("mthi busy done", done, 1'b1);
      end
      if (c == 35) check("mthi busy hi new", hi, 32'h00005555);
      tick();
    end
    start = 1'b0;
    check("mthi busy stall errs", serr, 0);
    m_hi = 32'h00005555;
    m_lo = exp[31:0];

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      f = 6'(6'h18 + $urandom_range(0, 3));
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i % 6 == 5) b = b >> $urandom_range(0, 31);
      run_op(f, a, b, 0, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Iterative multiply/divide sequencer sitting beside the execute stage, owning the architectural HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute, runs a 32-step shift-add multiply or restoring divide, and raises a stall so the pipeline interlocks MFHI/MFLO and further mul/div issue until the result lands. One operation is in flight at a time; a flush aborts it.

## Interface
- DWIDTH, 32, operand and HI/LO width; the step counter is $clog2(DWIDTH)+1 bits.
- FUNCT_WIDTH, 6, funct field width.
- md_i_clk  in  1  clock; all state updates on the rising edge.
- md_i_rst  in  1  synchronous, active-low reset.
- md_i_start  in  1  execute issues a mul/div/mt op this cycle; qualified by execute ce.
- md_i_funct  in  FUNCT_WIDTH  MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B, MTHI=0x11, MTLO=0x13; other codes are ignored.
- md_i_rs  in  DWIDTH  multiplicand / dividend / MT source.
- md_i_rt  in  DWIDTH  multiplier / divisor.
- md_i_mf_req  in  1  execute holds an MFHI/MFLO this cycle.
- md_i_flush  in  1  abort the in-flight operation (branch redirect).
- md_o_busy  out  1  state != IDLE.
- md_o_stall  out  1  combinational: md_o_busy && (md_i_start || md_i_mf_req).
- md_o_done  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- md_o_hi  out  DWIDTH  HI register.
- md_o_lo  out  DWIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with start and MULT/MULTU: latch |rs|, |rt| (the raw values for unsigned), a sign flag (rs[31]^rt[31], signed only), and a 64-bit accumulator of 0. Load counter = 32. Go to MUL.
- IDLE with start and DIV/DIVU: latch magnitudes, quotient sign (signs differ) and remainder sign (rs[31]), signed only. Go to DIV.
- IDLE with start and MTHI/MTLO: write rs to HI/LO at the edge. Stay IDLE; no done, no busy.
- MUL, each cycle: if multiplier[0] is set, add the multiplicand to the upper half. Then shift {acc, multiplier} right by 1 and decrement the counter. At counter 1, go to FIX.
- DIV, each cycle: shift {rem, quo} left by 1. Trial subtract the divisor from rem. If the result is non-negative, keep it and set quo[0]. Decrement the counter. At counter 1, go to FIX.
- FIX, one cycle:
  - Apply 2's-complement negation per the latched sign flags.
  - Write HI/LO: multiply gives HI=upper, LO=lower. Divide gives HI=remainder, LO=quotient.
  - Set done for the next cycle and go to IDLE.
- Divide by zero: LO=0xFFFFFFFF and HI=rs, for both signed and unsigned. Sign fix is bypassed. Normal latency.
- Start while busy is not accepted; md_o_stall holds execute, and the op is re-presented once idle.
- Flush in MUL/DIV/FIX: go to IDLE at the next edge. HI/LO are unchanged and no done is produced. Flush and start in the same IDLE cycle: flush wins and the op is dropped.
- Reset (md_i_rst=0): state=IDLE, counter=0, HI=LO=0, md_o_done=0, all internal accumulators 0. Reset mid-operation discards the operation.

## Timing
- Start sampled at the end of cycle 0.
- MUL/DIV occupy cycles 1–32 and FIX is cycle 33.
- New HI/LO are visible and md_o_done=1 in cycle 34. md_o_busy is high in cycles 1–33 and low in cycle 34.
- An MFHI/MFLO presented in cycles 1–33 stalls. In cycle 34 it reads the new value.
- MTHI/MTLO: the value is visible in the cycle after start.
- Outputs after reset: busy=0, stall=0 (unless inputs make it high while busy; busy is 0 after reset), done=0, hi=lo=0.

## Configuration
- MULDIV_EARLY_OUT_EN defined: in MUL, if the remaining unshifted multiplier is zero, shift the accumulator by the remaining count in one step and go to FIX.
  - Example: rt=0 gives MUL in cycle 1, FIX in cycle 2, done in cycle 3.
  - Example: rt=1 completes with done in cycle 3.
  - Divide latency is unchanged.
- Not defined: every multiply takes the full 32 MUL cycles, with done in cycle 34.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, done in cycle 34, busy cycles 1–33.
- DIVU rs=100, rt=7 -> LO=14, HI=2. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5, done in cycle 34.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then an MFHI request in cycle 5 -> stall=1 until cycle 34.
- With HI=0x11, start MULT, flush in cycle 10 -> busy=0 in cycle 11, HI=0x11, done never pulses. Reset low in cycle 20 of a DIV -> the next cycle shows IDLE, HI=LO=0.
- MTLO rs=0xABCD while idle -> LO=0xABCD next cycle, done=0. MTHI with start while busy -> stall=1 and HI is unchanged until re-issued after idle.
